// File: rtl/mult_sched_pkg.sv
// Shared types and default parameters for the multiplier request scheduler.
//   sched_state_e : scheduler FSM encoding (IDLE, ISSUE, WAIT, RESP)
//   DEF_*         : default values for the mult_sched parameters
package mult_sched_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_WIDTH   = 8;
  localparam int DEF_TIMEOUT = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req     : in  N          request vector
//   ptr     : in  clog2(N)   highest-priority index; search wraps from here
//   gnt     : out N          one-hot grant (all-zero when no request)
//   gnt_idx : out clog2(N)   index of the granted requester (0 when none)
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] idx;
  logic          found;

  // Walk the requesters starting at ptr; the first one found wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int i = 0; i < N; i++) begin
      idx = IW'((int'(ptr) + i) % N);
      if (!found && req[idx]) begin
        found      = 1'b1;
        gnt[idx]   = 1'b1;
        gnt_idx    = idx;
      end
    end
  end

endmodule

// File: rtl/mult_sched.sv
// Scheduler sharing one multiplier core between NUM_REQ requesters.
// Ports:
//   clk_i, rst_ni            clock (rising edge), async active-low reset
//   req_valid_i/req_m_i/req_n_i   per-requester operand pairs
//   req_ready_o              one-hot grant strobe (IDLE only)
//   mul_start_o/mul_m_o/mul_n_o   core issue: start pulse + held operands
//   mul_done_i/mul_result_i  core completion pulse + product
//   rsp_valid_o/rsp_ready_i/rsp_id_o/rsp_result_o/rsp_err_o  response channel
//   busy_o                   high whenever the FSM is not IDLE
//   state_o                  current FSM state (sched_state_e encoding)
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both high. req_ready_o is a one-cycle accept strobe that depends
// combinationally on req_valid_i; rsp_valid_o, once raised, stays high with
// stable fields until rsp_ready_i accepts it.
module mult_sched import mult_sched_pkg::*; #(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  input  logic [NUM_REQ*WIDTH-1:0]   req_m_i,
  input  logic [NUM_REQ*WIDTH-1:0]   req_n_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  output logic                       mul_start_o,
  output logic [WIDTH-1:0]           mul_m_o,
  output logic [WIDTH-1:0]           mul_n_o,
  input  logic                       mul_done_i,
  input  logic [2*WIDTH-1:0]         mul_result_i,
  output logic                       rsp_valid_o,
  input  logic                       rsp_ready_i,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id_o,
  output logic [2*WIDTH-1:0]         rsp_result_o,
  output logic                       rsp_err_o,
  output logic                       busy_o,
  output logic [1:0]                 state_o
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(TIMEOUT + 1);

  sched_state_e  state_q, state_d;
  logic [IDW-1:0] rr_ptr_q;
  logic [CW-1:0]  cnt_q;
  logic [NUM_REQ-1:0] gnt;
  logic [IDW-1:0]     gnt_idx;
  logic               grant_fire;
  logic               wait_expired;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req     (req_valid_i),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign grant_fire   = (state_q == IDLE) && (|req_valid_i);
  assign wait_expired = (cnt_q == CW'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state; a done arriving on the timeout cycle still counts as success.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (|req_valid_i) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (mul_done_i || wait_expired) state_d = RESP;
      RESP:    if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant is gated by rst_ni so the strobe stays low while reset is held,
  // even though requesters may already be raising valid.
  assign req_ready_o = (state_q == IDLE && rst_ni) ? gnt : '0;
  assign mul_start_o = (state_q == ISSUE);
  assign rsp_valid_o = (state_q == RESP);
  assign busy_o      = (state_q != IDLE);
  assign state_o     = state_q;

  // Datapath: operand/ID capture on grant, timeout counter, response capture.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q     <= '0;
      cnt_q        <= '0;
      mul_m_o      <= '0;
      mul_n_o      <= '0;
      rsp_id_o     <= '0;
      rsp_result_o <= '0;
      rsp_err_o    <= 1'b0;
    end else begin
      if (grant_fire) begin
        mul_m_o  <= req_m_i[gnt_idx*WIDTH +: WIDTH];
        mul_n_o  <= req_n_i[gnt_idx*WIDTH +: WIDTH];
        rsp_id_o <= gnt_idx;
        rr_ptr_q <= (gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
      if (state_q == ISSUE) cnt_q <= '0;
      if (state_q == WAIT) begin
        if (mul_done_i) begin
          rsp_result_o <= mul_result_i;
          rsp_err_o    <= 1'b0;
        end else if (wait_expired) begin
          rsp_result_o <= '0;
          rsp_err_o    <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mult_sched.sv
module tb_mult_sched;

  localparam int NR = 4;
  localparam int W  = 8;
  localparam int K  = 5;   // core model latency
  localparam int EW = 19;  // {id[1:0], result[15:0], err}

  logic            clk_i, rst_ni;
  logic [NR-1:0]   req_valid_i;
  logic [NR*W-1:0] req_m_i, req_n_i;
  logic [NR-1:0]   req_ready_o;
  logic            mul_start_o;
  logic [W-1:0]    mul_m_o, mul_n_o;
  logic            mul_done_i;
  logic [2*W-1:0]  mul_result_i;
  logic            rsp_valid_o, rsp_ready_i;
  logic [1:0]      rsp_id_o;
  logic [2*W-1:0]  rsp_result_o;
  logic            rsp_err_o, busy_o;
  logic [1:0]      state_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [EW-1:0] exp_q[$];
  logic [NR-1:0] exp_gnt_q[$];
  int            exp_lat_q[$];

  logic core_en    = 1'b1;
  logic force_done = 1'b0;
  int   core_cnt   = 0;

  mult_sched dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_m_i(req_m_i), .req_n_i(req_n_i),
    .req_ready_o(req_ready_o),
    .mul_start_o(mul_start_o), .mul_m_o(mul_m_o), .mul_n_o(mul_n_o),
    .mul_done_i(mul_done_i), .mul_result_i(mul_result_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_id_o(rsp_id_o), .rsp_result_o(rsp_result_o), .rsp_err_o(rsp_err_o),
    .busy_o(busy_o), .state_o(state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- core model ----------------
  // Product is formed from mul_m_o/mul_n_o at done time, so operands that
  // are not held stable would show up as a wrong result.
  initial begin
    logic signed [2*W-1:0] a, b;
    mul_done_i   = 1'b0;
    mul_result_i = '0;
    forever begin
      @(negedge clk_i);
      mul_done_i = 1'b0;
      if (core_cnt != 0) begin
        core_cnt--;
        if (core_cnt == 0) begin
          a = {{W{mul_m_o[W-1]}}, mul_m_o};
          b = {{W{mul_n_o[W-1]}}, mul_n_o};
          mul_done_i   = 1'b1;
          mul_result_i = a * b;
        end
      end
      if (force_done) begin
        mul_done_i   = 1'b1;
        mul_result_i = 16'h1234;
      end
      if (mul_start_o && core_en) core_cnt = K;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    int   gnt_cyc;
    logic prev_v;
    gnt_cyc = 0;
    prev_v  = 1'b0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        prev_v = 1'b0;
      end else begin
        if (req_ready_o != '0) begin
          if (exp_gnt_q.size() == 0) chk("unexpected_grant", 32'(req_ready_o), 0);
          else chk("grant", 32'(req_ready_o), 32'(exp_gnt_q.pop_front()));
          gnt_cyc = cyc;
        end
        if (mul_start_o) chk("start_latency", cyc - gnt_cyc, 1);
        if (rsp_valid_o && !prev_v) begin
          if (exp_lat_q.size() == 0) chk("unexpected_rsp", 32'(rsp_valid_o), 0);
          else chk("rsp_latency", cyc - gnt_cyc, exp_lat_q.pop_front());
        end
        if (rsp_valid_o && rsp_ready_i) begin
          if (exp_q.size() == 0) chk("unexpected_rsp_hs", 32'(rsp_valid_o), 0);
          else chk("rsp", 32'({rsp_id_o, rsp_result_o, rsp_err_o}), 32'(exp_q.pop_front()));
        end
        prev_v = rsp_valid_o;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic expect_op(input int id, input logic [15:0] res, input logic err, input int lat);
    exp_gnt_q.push_back(NR'(1 << id));
    exp_q.push_back({2'(id), res, err});
    exp_lat_q.push_back(lat);
  endtask

  task automatic set_req(input int id, input logic [7:0] m, input logic [7:0] n);
    req_m_i[id*W +: W] = m;
    req_n_i[id*W +: W] = n;
    req_valid_i[id]    = 1'b1;
  endtask

  // Returns one cycle after the grant (the ISSUE cycle).
  task automatic wait_grant(input int id);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk_i);
      if (req_ready_o[id]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("grant_wait_timeout", 32'(req_ready_o), 32'(1 << id));
    tick();
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 300; n++) begin
      @(negedge clk_i);
      if (!busy_o) break;
    end
    if (busy_o) chk("idle_wait_timeout", 32'(busy_o), 0);
    tick();
  endtask

  task automatic run_one(input int id, input logic [7:0] m, input logic [7:0] n,
                         input logic [15:0] res, input logic err, input int lat);
    expect_op(id, res, err, lat);
    set_req(id, m, n);
    wait_grant(id);
    req_valid_i[id] = 1'b0;
    wait_idle();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready_o), 0);
    chk({tag, "_mul_start"}, 32'(mul_start_o), 0);
    chk({tag, "_mul_m"}, 32'(mul_m_o), 0);
    chk({tag, "_mul_n"}, 32'(mul_n_o), 0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid_o), 0);
    chk({tag, "_rsp_id"}, 32'(rsp_id_o), 0);
    chk({tag, "_rsp_result"}, 32'(rsp_result_o), 0);
    chk({tag, "_rsp_err"}, 32'(rsp_err_o), 0);
    chk({tag, "_busy"}, 32'(busy_o), 0);
    chk({tag, "_state"}, 32'(state_o), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int seq[5];
    rst_ni      = 1'b0;
    req_valid_i = '1;       // requests during reset must not be granted
    req_m_i     = '0;
    req_n_i     = '0;
    rsp_ready_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    check_all_zero("reset");
    req_valid_i = '0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();

    // single request from requester 2: 3*5
    run_one(2, 8'h03, 8'h05, 16'h000F, 1'b0, 7);

    // signed operands
    run_one(0, 8'hFE, 8'h07, 16'hFFF2, 1'b0, 7);
    run_one(1, 8'h80, 8'h80, 16'h4000, 1'b0, 7);

    // back-pressure: requester 3 responds while requester 0 waits
    rsp_ready_i = 1'b0;
    expect_op(3, 16'h0030, 1'b0, 7);
    set_req(3, 8'h10, 8'h03);
    wait_grant(3);
    req_valid_i[3] = 1'b0;
    expect_op(0, 16'hFFE7, 1'b0, 7);
    set_req(0, 8'h05, 8'hFB);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk_i);
      if (rsp_valid_o) break;
    end
    for (int n = 0; n < 10; n++) begin
      @(negedge clk_i);
      chk("bp_rsp_valid", 32'(rsp_valid_o), 1);
      chk("bp_rsp_id", 32'(rsp_id_o), 3);
      chk("bp_rsp_result", 32'(rsp_result_o), 32'h0030);
      chk("bp_rsp_err", 32'(rsp_err_o), 0);
      chk("bp_req_ready", 32'(req_ready_o), 0);
      chk("bp_mul_start", 32'(mul_start_o), 0);
    end
    tick();
    rsp_ready_i = 1'b1;
    wait_grant(0);
    req_valid_i[0] = 1'b0;
    wait_idle();

    // timeout: core never answers
    core_en = 1'b0;
    run_one(1, 8'h01, 8'h01, 16'h0000, 1'b1, 66);
    force_done = 1'b1;      // stray late done while idle
    tick();
    force_done = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk_i);
      chk("stray_rsp_valid", 32'(rsp_valid_o), 0);
      chk("stray_busy", 32'(busy_o), 0);
    end
    tick();

    // reset while waiting on the core (rr_ptr is 3 after this grant)
    exp_gnt_q.push_back(4'b0100);
    set_req(2, 8'h02, 8'h02);
    wait_grant(2);
    req_valid_i[2] = 1'b0;
    repeat (4) tick();
    chk("pre_reset_state_wait", 32'(state_o), 2);
    #2;
    rst_ni = 1'b0;
    #1;
    check_all_zero("async_reset");
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni  = 1'b1;
    core_en = 1'b1;
    tick();

    // all four continuously valid: order 0,1,2,3,0 from a fresh rr_ptr
    seq = '{0, 1, 2, 3, 0};
    expect_op(0, 16'h000C, 1'b0, 7);
    expect_op(1, 16'hFF81, 1'b0, 7);
    expect_op(2, 16'h3F01, 1'b0, 7);
    expect_op(3, 16'hC080, 1'b0, 7);
    expect_op(0, 16'h000C, 1'b0, 7);
    set_req(0, 8'h03, 8'h04);
    set_req(1, 8'hFF, 8'h7F);
    set_req(2, 8'h7F, 8'h7F);
    set_req(3, 8'h80, 8'h7F);
    for (int i = 0; i < 5; i++) begin
      wait_grant(seq[i]);
      if (i != 0) req_valid_i[seq[i]] = 1'b0;
    end
    wait_idle();
    repeat (5) tick();

    chk("exp_q_drained", exp_q.size(), 0);
    chk("exp_gnt_q_drained", exp_gnt_q.size(), 0);
    chk("exp_lat_q_drained", exp_lat_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
